// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode renderer: palette, cell layout,
// fetch FSM states and the cell record passed to the glyph shifter.
package text_pkg;

    localparam int CHAR_LSB = 0;
    localparam int FG_LSB   = 8;
    localparam int BG_LSB   = 12;

    // Fixed 16-colour palette, RGB 4:4:4 with red in the top nibble; entry 0 doubles as border.
    localparam logic [15:0][11:0] PALETTE = {
        12'hFFF, 12'hFF5, 12'hF5F, 12'hF55, 12'h5FF, 12'h5F5, 12'h55F, 12'h555,
        12'hAAA, 12'hA50, 12'hA0A, 12'hA00, 12'h0AA, 12'h0A0, 12'h00A, 12'h000
    };

    typedef enum logic [2:0] {
        IDLE,
        VREQ,
        FREQ,
        LATCH,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [7:0] glyph;
        logic [3:0] fg;
        logic [3:0] bg;
        logic       cursor;
    } cell_t;

endpackage

// File: rtl/glyph_shifter.sv
// Two-deep cell pipeline: a prefetch buffer feeding an 8-bit glyph shifter,
// each glyph bit held for PIXEL_REP advance slots.
module glyph_shifter
    import text_pkg::*;
#(
    parameter int PIXEL_REP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       load,
    input  cell_t      load_cell,
    input  logic       advance,
    input  logic       blink_phase,
    output logic       buf_empty,
    output logic       shift_valid,
    output logic [3:0] color_idx
);

    localparam logic [1:0] SLOT_LAST = 2'(PIXEL_REP - 1);

    cell_t      shift_q, shift_d;
    cell_t      buf_q, buf_d;
    logic       shift_valid_q, shift_valid_d;
    logic       buf_valid_q, buf_valid_d;
    logic [1:0] slot_q, slot_d;
    logic [2:0] bit_q, bit_d;
    logic       pix_bit;

    always_comb begin
        shift_d       = shift_q;
        buf_d         = buf_q;
        shift_valid_d = shift_valid_q;
        buf_valid_d   = buf_valid_q;
        slot_d        = slot_q;
        bit_d         = bit_q;

        if (shift_valid_q && advance) begin
            if (slot_q == SLOT_LAST) begin
                slot_d        = '0;
                bit_d         = bit_q + 3'd1;
                shift_d.glyph = {shift_q.glyph[6:0], 1'b0};
                // Last slot of the last bit: the buffered cell takes over on this same edge.
                if (bit_q == 3'd7) begin
                    shift_d       = buf_q;
                    shift_valid_d = buf_valid_q;
                    buf_valid_d   = 1'b0;
                end
            end else begin
                slot_d = slot_q + 2'd1;
            end
        end

        if (load) begin
            if (!shift_valid_d) begin
                shift_d       = load_cell;
                shift_valid_d = 1'b1;
                slot_d        = '0;
                bit_d         = '0;
            end else begin
                buf_d       = load_cell;
                buf_valid_d = 1'b1;
            end
        end

        if (flush) begin
            shift_valid_d = 1'b0;
            buf_valid_d   = 1'b0;
            slot_d        = '0;
            bit_d         = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q       <= '0;
            buf_q         <= '0;
            shift_valid_q <= 1'b0;
            buf_valid_q   <= 1'b0;
            slot_q        <= '0;
            bit_q         <= '0;
        end else begin
            shift_q       <= shift_d;
            buf_q         <= buf_d;
            shift_valid_q <= shift_valid_d;
            buf_valid_q   <= buf_valid_d;
            slot_q        <= slot_d;
            bit_q         <= bit_d;
        end
    end

    // A cursor cell in the visible blink phase shows inverted colours.
    assign pix_bit     = shift_q.glyph[7] ^ (shift_q.cursor & blink_phase);
    assign color_idx   = pix_bit ? shift_q.fg : shift_q.bg;
    assign shift_valid = shift_valid_q;
    assign buf_empty   = !buf_valid_q;

endmodule

// File: rtl/text_renderer.sv
// Text-mode pixel generator: fetches char/attribute cells and glyph lines for a
// scanline and streams palette-mapped RGB pixels through glyph_shifter.
module text_renderer
    import text_pkg::*;
#(
    parameter int COLS       = 80,
    parameter int STRIDE_LG2 = 7,
    parameter int FONT_H_LG2 = 3,
    parameter int PIXEL_REP  = 2,
    parameter int BLINK_LG2  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        newline,
    input  logic [8:0]  line,
    input  logic        advance,
    input  logic        vsync,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [5:0]  cursor_row,
    output logic [12:0] vram_addr,
    input  logic [15:0] vram_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        ready,
    output logic [11:0] pixel
);

    localparam int ROW_W  = 9 - FONT_H_LG2;
    localparam int COL_W  = STRIDE_LG2 + 1;
    localparam int FONT_H = 1 << FONT_H_LG2;

    fetch_state_t           state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [FONT_H_LG2-1:0]  gline_q, gline_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [12:0]            vram_addr_q, vram_addr_d;
    logic [11:0]            font_addr_q, font_addr_d;
    logic [3:0]             fg_q, fg_d, bg_q, bg_d;
    logic                   cursor_q, cursor_d;
    logic [BLINK_LG2:0]     blink_q, blink_d;
    logic                   ready_q, ready_d;
    logic                   load, cursor_hit, buf_empty, shift_valid;
    logic [3:0]             color_idx;
    cell_t                  load_cell;

    function automatic logic [12:0] cell_addr(input logic [ROW_W-1:0] row,
                                              input logic [COL_W-1:0] col);
        return 13'((32'(row) << STRIDE_LG2) | 32'(col));
    endfunction

    assign cursor_hit = cursor_en
                      && (int'(col_q) == int'(cursor_col))
                      && (int'(row_q) == int'(cursor_row))
                      && (int'(gline_q) >= FONT_H - 2);

    // font_addr is driven straight from vram_data in FREQ so the glyph is back one cycle later.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        gline_d     = gline_q;
        col_d       = col_q;
        vram_addr_d = vram_addr_q;
        font_addr_d = font_addr_q;
        fg_d        = fg_q;
        bg_d        = bg_q;
        cursor_d    = cursor_q;
        ready_d     = ready_q;
        load        = 1'b0;
        blink_d     = vsync ? blink_q + 1'b1 : blink_q;

        case (state_q)
            VREQ: state_d = FREQ;
            FREQ: begin
                font_addr_d = 12'((32'(vram_data[CHAR_LSB +: 8]) << FONT_H_LG2) | 32'(gline_q));
                fg_d        = vram_data[FG_LSB +: 4];
                bg_d        = vram_data[BG_LSB +: 4];
                cursor_d    = cursor_hit;
                state_d     = LATCH;
            end
            LATCH: begin
                load    = 1'b1;
                ready_d = 1'b1;
                col_d   = col_q + 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (buf_empty && int'(col_q) < COLS) begin
                    vram_addr_d = cell_addr(row_q, col_q);
                    state_d     = VREQ;
                end
            end
            default: ;
        endcase

        if (newline) begin
            row_d       = ROW_W'(line >> FONT_H_LG2);
            gline_d     = line[FONT_H_LG2-1:0];
            col_d       = '0;
            vram_addr_d = cell_addr(row_d, '0);
            ready_d     = 1'b0;
            load        = 1'b0;
            state_d     = VREQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            gline_q     <= '0;
            col_q       <= '0;
            vram_addr_q <= '0;
            font_addr_q <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            cursor_q    <= 1'b0;
            blink_q     <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            gline_q     <= gline_d;
            col_q       <= col_d;
            vram_addr_q <= vram_addr_d;
            font_addr_q <= font_addr_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            cursor_q    <= cursor_d;
            blink_q     <= blink_d;
            ready_q     <= ready_d;
        end
    end

    assign load_cell = '{glyph: font_data, fg: fg_q, bg: bg_q, cursor: cursor_q};

    glyph_shifter #(
        .PIXEL_REP(PIXEL_REP)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (newline),
        .load       (load),
        .load_cell  (load_cell),
        .advance    (advance),
        .blink_phase(blink_q[BLINK_LG2]),
        .buf_empty  (buf_empty),
        .shift_valid(shift_valid),
        .color_idx  (color_idx)
    );

    // Once the row has started, an exhausted shifter means we are past the last cell: border colour.
    assign pixel     = !ready_q ? 12'h000 : (shift_valid ? PALETTE[color_idx] : PALETTE[0]);
    assign ready     = ready_q;
    assign vram_addr = vram_addr_q;
    assign font_addr = font_addr_d;

endmodule

// File: tb/tb_text_renderer.sv
// Directed self-checking bench for text_renderer: an 8-line-font instance carries
// most tests, a 16-line-font instance covers the 4-bit glyph-line regression.
module tb_text_renderer;

    localparam int COLS = 80;
    localparam int REP  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        newline = 1'b0;
    logic [8:0]  line = '0;
    logic        advance = 1'b0;
    logic        vsync = 1'b0;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [5:0]  cursor_row = '0;

    logic [12:0] vram_addr, vram_addr2;
    logic [15:0] vram_data, vram_data2;
    logic [11:0] font_addr, font_addr2;
    logic [7:0]  font_data, font_data2;
    logic        ready, ready2;
    logic [11:0] pixel, pixel2;

    logic [15:0] vram [8192];
    logic [7:0]  font [4096];
    logic [11:0] pal  [16];
    logic [11:0] t1_exp [16];

    int checks = 0;
    int errors = 0;
    int vsync_count = 0;
    int last_max = 0;

    always #5 clk = ~clk;

    // Synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        vram_data  <= vram[vram_addr];
        font_data  <= font[font_addr];
        vram_data2 <= vram[vram_addr2];
        font_data2 <= font[font_addr2];
    end

    text_renderer #(
        .COLS(COLS), .STRIDE_LG2(7), .FONT_H_LG2(3), .PIXEL_REP(REP), .BLINK_LG2(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .newline(newline), .line(line), .advance(advance),
        .vsync(vsync), .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .vram_addr(vram_addr), .vram_data(vram_data), .font_addr(font_addr),
        .font_data(font_data), .ready(ready), .pixel(pixel)
    );

    text_renderer #(
        .COLS(COLS), .STRIDE_LG2(7), .FONT_H_LG2(4), .PIXEL_REP(REP), .BLINK_LG2(5)
    ) dut16 (
        .clk(clk), .rst_n(rst_n), .newline(newline), .line(line), .advance(advance),
        .vsync(vsync), .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .vram_addr(vram_addr2), .vram_data(vram_data2), .font_addr(font_addr2),
        .font_data(font_data2), .ready(ready2), .pixel(pixel2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected pixel for slot k of a row on the 8-line-font instance.
    function automatic logic [11:0] expPixel(input int base, input int gl, input int row, input int k);
        int         c;
        int         b;
        logic [15:0] w;
        logic [7:0]  g;
        logic        bitv;
        c = k / (8 * REP);
        b = (k / REP) % 8;
        if (c >= COLS) return pal[0];
        w    = vram[base + c];
        g    = font[int'(w[7:0]) * 8 + gl];
        bitv = g[7 - b];
        if (cursor_en && c == int'(cursor_col) && row == int'(cursor_row) && gl >= 6
            && ((vsync_count / 32) % 2) == 1)
            bitv = ~bitv;
        return bitv ? pal[w[11:8]] : pal[w[15:12]];
    endfunction

    // Issue a newline pulse; returns #1 into the cycle after the pulse.
    task automatic applyStimulus(input logic [8:0] ln);
        line    = ln;
        newline = 1'b1;
        @(posedge clk); #1;
        newline = 1'b0;
    endtask

    task automatic pulseVsync(input int n);
        for (int i = 0; i < n; i++) begin
            vsync = 1'b1;
            @(posedge clk); #1;
            vsync = 1'b0;
            vsync_count++;
            @(posedge clk); #1;
        end
    endtask

    // Start a row, check fetch timing, then check nslots pixels with advance held high.
    task automatic checkRow(input logic [8:0] ln, input int nslots, input string tag);
        int base;
        int gl;
        int row;
        int maxa;
        row  = int'(ln) >> 3;
        gl   = int'(ln) & 7;
        base = row << 7;
        applyStimulus(ln);
        checkOutput({tag, "_vaddr"}, 32'(vram_addr), base);
        checkOutput({tag, "_rdy1"}, 32'(ready), 0);
        @(posedge clk); #1;
        checkOutput({tag, "_faddr"}, 32'(font_addr), int'(vram[base][7:0]) * 8 + gl);
        @(posedge clk); #1;
        checkOutput({tag, "_rdy3"}, 32'(ready), 0);
        @(posedge clk); #1;
        checkOutput({tag, "_rdy4"}, 32'(ready), 1);
        maxa = base;
        for (int k = 0; k < nslots; k++) begin
            checkOutput({tag, "_pix"}, 32'(pixel), 32'(expPixel(base, gl, row, k)));
            if (int'(vram_addr) > maxa) maxa = int'(vram_addr);
            @(posedge clk); #1;
        end
        last_max = maxa;
    endtask

    initial begin
        pal = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
        // 'A' glyph line 8'h18 with fg F / bg 1: six bg slots, four fg slots, six bg slots.
        t1_exp = '{12'h00A, 12'h00A, 12'h00A, 12'h00A, 12'h00A, 12'h00A, 12'hFFF, 12'hFFF,
                   12'hFFF, 12'hFFF, 12'h00A, 12'h00A, 12'h00A, 12'h00A, 12'h00A, 12'h00A};
        for (int i = 0; i < 8192; i++) vram[i] = {4'(i * 3 + 1), 4'(i * 7 + 2), 8'(i * 13 + 5)};
        for (int i = 0; i < 4096; i++) font[i] = 8'(i * 37 + 11);
        vram[0]         = 16'h1F41;
        font[12'h208]   = 8'h18;
        vram[261]       = 16'h2E33;
        font[12'h19F]   = 8'hF0;
        vram[128]       = 16'h1F41;
        font[12'h41D]   = 8'h18;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(ready), 0);
        checkOutput("rst_pixel", 32'(pixel), 0);
        checkOutput("rst_vaddr", 32'(vram_addr), 0);
        checkOutput("rst_faddr", 32'(font_addr), 0);
        rst_n = 1'b1;
        advance = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("idle_ready", 32'(ready), 0);
        end

        // Test 1: first cell of line 0, hand-computed pixel run
        checkRow(9'd0, 0, "t1");
        for (int k = 0; k < 16; k++) begin
            checkOutput("t1_hand", 32'(pixel), 32'(t1_exp[k]));
            @(posedge clk); #1;
        end

        // Tests 2/3: line 19 -> row 2, gline 3; full row plus border tail
        checkRow(9'd19, COLS * 8 * REP + 8, "t3");
        checkOutput("t3_vmax", last_max, 256 + COLS - 1);

        // Test 4: cursor at (5,2) on line 23, phase 1 then phase 0
        cursor_en  = 1'b1;
        cursor_col = 7'd5;
        cursor_row = 6'd2;
        pulseVsync(32);
        checkRow(9'd23, 7 * 16, "t4on");
        pulseVsync(32);
        checkRow(9'd23, 7 * 16, "t4off");
        cursor_en = 1'b0;

        // Test 5: newline mid-cell 10 with advance high
        checkRow(9'd40, 10 * 16 + 5, "t5a");
        checkRow(9'd48, 32, "t5b");

        // Test 6: asynchronous reset mid-row, then recovery
        checkRow(9'd8, 50, "t6a");
        #2;
        rst_n = 1'b0;
        vsync_count = 0;
        #1;
        checkOutput("t6_ready", 32'(ready), 0);
        checkOutput("t6_pixel", 32'(pixel), 0);
        checkOutput("t6_vaddr", 32'(vram_addr), 0);
        checkOutput("t6_faddr", 32'(font_addr), 0);
        checkOutput("t6_pixel2", 32'(pixel2), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checkOutput("t6_hold_rdy", 32'(ready), 0);
            checkOutput("t6_hold_pix", 32'(pixel), 0);
        end
        checkRow(9'd8, 32, "t6b");

        // 16-line font regression: line 29 -> row 1, gline 13
        applyStimulus(9'd29);
        checkOutput("t6h_vaddr", 32'(vram_addr2), 128);
        checkOutput("t6h_rdy1", 32'(ready2), 0);
        @(posedge clk); #1;
        checkOutput("t6h_faddr", 32'(font_addr2), 32'h41D);
        @(posedge clk); #1;
        checkOutput("t6h_rdy3", 32'(ready2), 0);
        @(posedge clk); #1;
        checkOutput("t6h_rdy4", 32'(ready2), 1);
        for (int k = 0; k < 16; k++) begin
            checkOutput("t6h_pix", 32'(pixel2), 32'(t1_exp[k]));
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
